// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-8 frame distributor.
package demux_pkg;

  localparam int WIDTH = 16;
  localparam int LANES = 8;

  // FILL collects words into lanes, HOLD presents the frame to the consumer
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic [2:0] lane_idx_t;

  // One-hot lane mask bit for a given lane index
  function automatic logic [LANES-1:0] laneOneHot(input lane_idx_t idx);
    return LANES'(1) << idx;
  endfunction

endpackage

// File: rtl/demux_lane_bank.sv
// Eight data registers plus the written-lane mask for one frame.
module demux_lane_bank
  import demux_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_we,
  input  lane_idx_t                   i_idx,
  input  logic [WIDTH-1:0]            i_data,
  input  logic                        i_clearMask,
  output logic [LANES-1:0][WIDTH-1:0] o_lanes,
  output logic [LANES-1:0]            o_mask,
  output logic                        o_oldBit
);

  logic [LANES-1:0][WIDTH-1:0] r_lanes;
  logic [LANES-1:0]            r_mask;

  // Lane data: cleared only by reset, otherwise kept until the lane is rewritten
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lanes <= '0;
    end else if (i_we) begin
      r_lanes[i_idx] <= i_data;
    end
  end

  // Mask tracks which lanes were written since the last frame handoff
  always_ff @(posedge clk) begin
    if (rst || i_clearMask) begin
      r_mask <= '0;
    end else if (i_we) begin
      r_mask <= r_mask | laneOneHot(i_idx);
    end
  end

  assign o_lanes  = r_lanes;
  assign o_mask   = r_mask;
  assign o_oldBit = r_mask[i_idx];

endmodule

// File: rtl/demux_1x8_16bit_frame.sv
// Registered 1-to-8 word distributor: fills eight lanes and hands the frame off.
module demux_1x8_16bit_frame
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             addr_mode,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  input  logic             flush,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [LANES-1:0] lane_mask,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             dup_err
);

  state_t                      r_state;
  state_t                      w_nextState;
  lane_idx_t                   r_ptr;
  lane_idx_t                   w_idx;
  logic                        r_dupErr;
  logic                        w_accept;
  logic                        w_clearMask;
  logic                        w_oldBit;
  logic [LANES-1:0]            w_mask;
  logic [LANES-1:0]            w_nextMask;
  logic [LANES-1:0][WIDTH-1:0] w_lanes;

  assign w_accept   = in_valid & in_ready;
  assign w_idx      = addr_mode ? {s2, s1, s0} : r_ptr;
  assign w_nextMask = w_mask | (w_accept ? laneOneHot(w_idx) : '0);

  demux_lane_bank u_bank (
    .clk         (clk),
    .rst         (rst),
    .i_we        (w_accept),
    .i_idx       (w_idx),
    .i_data      (in_data),
    .i_clearMask (w_clearMask),
    .o_lanes     (w_lanes),
    .o_mask      (w_mask),
    .o_oldBit    (w_oldBit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: complete or flushed-nonempty frame goes to HOLD, consumer take returns to FILL
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FILL: begin
        if (w_nextMask == '1 || (flush && w_nextMask != '0)) begin
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          w_nextState = FILL;
        end
      end
      default: w_nextState = FILL;
    endcase
  end

  // Handshake outputs decoded purely from the state register
  always_comb begin
    in_ready    = (r_state == FILL);
    frame_valid = (r_state == HOLD);
    w_clearMask = (r_state == HOLD) && frame_ready;
  end

  // Lane pointer advances only on sequential accepts and rewinds on frame handoff
  always_ff @(posedge clk) begin
    if (rst || w_clearMask) begin
      r_ptr <= '0;
    end else if (w_accept && !addr_mode) begin
      r_ptr <= r_ptr + 3'd1;
    end
  end

  // Duplicate-write pulse raised the cycle after a word lands on an already-written lane
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dupErr <= 1'b0;
    end else begin
      r_dupErr <= w_accept & w_oldBit;
    end
  end

  assign dup_err   = r_dupErr;
  assign lane_mask = w_mask;
  assign out1      = w_lanes[0];
  assign out2      = w_lanes[1];
  assign out3      = w_lanes[2];
  assign out4      = w_lanes[3];
  assign out5      = w_lanes[4];
  assign out6      = w_lanes[5];
  assign out7      = w_lanes[6];
  assign out8      = w_lanes[7];

endmodule

// File: doc/demux_1x8_16bit_frame.md
Name: demux_1x8_16bit_frame

Overview:
Registered 1-to-8 data distributor: the inverse of the team's 8-input, 16-bit data-select mux.
- Accepts a stream of 16-bit words on a valid/ready input.
- Steers each word into one of eight output lane registers, either by a running lane pointer or by explicit select bits {s2,s1,s0}.
- Presents the assembled 8-lane frame with a valid/ready handshake.
- Sits in front of blocks that consume eight parallel 16-bit operands.

Parameters:
WIDTH, 16, data width of input word and of each output lane.
LANES, 8, number of output lanes. Fixed at 8 so the select is exactly 3 bits.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_data  input  16  word to distribute
in_valid  input  1  in_data valid this cycle
in_ready  output  1  block can accept a word this cycle
addr_mode  input  1  0 = sequential (lane pointer), 1 = addressed (lane = {s2,s1,s0})
s0  input  1  lane select bit 0 (LSB), used when addr_mode=1
s1  input  1  lane select bit 1
s2  input  1  lane select bit 2 (MSB)
flush  input  1  emit a partially filled frame
out1..out8  output  16 each  lane registers; out1 = lane 0 ... out8 = lane 7
lane_mask  output  8  bit k set = lane k written in current frame
frame_valid  output  1  frame complete and held stable
frame_ready  input  1  consumer takes the frame
dup_err  output  1  one-cycle pulse: an accepted word overwrote an already-written lane

Behaviour:
- Reset (rst=1 at a clock edge, from any state, including mid-frame):
  - state=FILL, ptr=0, lane_mask=0, out1..out8=0, frame_valid=0, dup_err=0.
  - A partial frame is discarded.
- States: FILL, HOLD.
- in_ready = (state==FILL), decoded from the state register only. It never depends on in_valid.
- frame_valid = (state==HOLD).
- Accept = in_valid & in_ready.
- FILL, on accept:
  - Target lane: addr_mode ? {s2,s1,s0} : ptr.
  - Write in_data to that lane and set its lane_mask bit.
  - ptr increments by 1 (wrapping 7→0) only on sequential-mode accepts. Addressed accepts leave ptr unchanged.
  - addr_mode is sampled per accepted word. Mixing modes within a frame is legal.
  - If the target lane's mask bit was already set: overwrite the lane and pulse dup_err high the next cycle.
- FILL → HOLD when the next lane_mask value equals 8'hFF.
  - frame_valid rises the cycle after the completing word is accepted (latency 1).
- FILL with flush=1:
  - If the next lane_mask is non-zero, go to HOLD with the partial lane_mask.
  - If flush and an accept occur in the same cycle, the word is written first, then the block goes to HOLD.
  - flush with next lane_mask==0 is ignored and the block stays in FILL.
- HOLD:
  - in_ready=0; out1..out8 and lane_mask are held stable.
  - flush is ignored.
  - On frame_ready=1: next cycle lane_mask=0, ptr=0, state=FILL.
  - Lane data registers keep their old values; they are not cleared.
  - One bubble cycle: no word is accepted in the cycle frame_ready is sampled.
- frame_ready while in FILL has no effect.
- in_valid while in HOLD: the word is not accepted. The source must hold it (standard valid/ready rule).
- Unwritten lanes in a partial frame show stale data. Consumers must qualify lanes with lane_mask.

Decomposition:
- Shared package `demux_pkg`:
  - WIDTH and LANES constants.
  - State enum {FILL, HOLD}.
  - Lane-index type (3 bits).
- One sub-module `demux_lane_bank`:
  - Eight WIDTH-bit registers plus the 8-bit mask.
  - Write-enable and lane index in; clear-mask and reset in.
  - Returns the old mask bit, used for dup_err.
- Top level holds the FSM, ptr, flush logic and the handshake.

Test Plan:
- Sequential fill: reset; addr_mode=0; send 0x0011, 0x0022 … 0x0088 back-to-back → frame_valid high the cycle after the 8th accept; out1=0x0011 … out8=0x0088; lane_mask=0xFF; in_ready=0.
- Addressed fill with reorder: addr_mode=1; write lanes 7,0,3,1,6,2,5,4 with data 0xA000+lane → outK = 0xA000+(K-1); frame_valid only after the 8th word; dup_err never pulses.
- Duplicate lane: addressed writes 0x1111 then 0x2222 to lane 3 → out4=0x2222; dup_err pulses exactly one cycle; lane_mask=0x08.
- Flush partial: 3 sequential words, then flush with a 4th word in the same cycle → HOLD with lane_mask=0x0F; flush in an empty FILL → no state change.
- Backpressure and release: hold frame_ready=0 for 5 cycles in HOLD with in_valid=1 → outputs stable, no accept. Then frame_ready=1 → next cycle state is FILL, ptr=0, lane_mask=0, and the next word lands in out1.
- Reset mid-frame: rst=1 after 4 words → all outputs 0, lane_mask=0, ptr=0. The next word lands in out1.
